axi_mul_engine: RTL

//  Parametrised successor of the two-operand read/multiply/write datapath. From a start pulse it runs
//  a job of COUNT multiply operations over AXI-lite-style channels: read operand A[i], read operand
//  B[i], multiply, then write the product (mode 0) or write one accumulated sum at job end (mode 1).

---
 rtl/axi_mul_engine_if.sv | 30 +++
 rtl/axi_mul_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/axi_mul_engine_if.sv
// axi_mul_engine_if: AXI-lite style read/write channels between the multiply engine and the memory fabric
interface axi_mul_engine_if #(
  parameter int DW = 16,
  parameter int AW = 32
);
  logic [AW-1:0]   m_araddr;
  logic            m_arvalid;
  logic            s_arready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rvalid;
  logic            m_rready;
  logic [AW-1:0]   m_awaddr;
  logic            m_awvalid;
  logic            s_awready;
  logic [2*DW-1:0] m_wdata;
  logic            m_wvalid;
  logic            s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            m_bready;
  modport master (
    output m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid
  );
  modport slave (
    input  m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid
  );
endinterface

// File: rtl/axi_mul_engine.sv
// axi_mul_engine: bus master that reads operand pairs, multiplies them and writes each product or their sum
module axi_mul_engine #(
  parameter int DW        = 16,
  parameter int AW        = 32,
  parameter int CNT_W     = 8,
  parameter int ADDR_STEP = 4
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                start,
  input  logic                mode,
  input  logic [CNT_W-1:0]    count,
  input  logic [AW-1:0]       raddr1,
  input  logic [AW-1:0]       raddr2,
  input  logic [AW-1:0]       waddr,
  axi_mul_engine_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ovf,
  output logic [CNT_W-1:0]    op_index
);
  localparam logic [AW-1:0] step = AW'(ADDR_STEP);
  typedef enum logic [3:0] {IDLE, AR1, R1, AR2, R2, MUL, WR, B, DONE} state_t;
  state_t          state;
  logic            mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]   pa, pb, pw;
  logic [DW-1:0]   a_q, b_q;
  logic [2*DW-1:0] acc, prod;
  logic [2*DW:0]   sum;
  logic            last;
  assign prod = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
  assign sum  = {1'b0, acc} + {1'b0, prod};
  assign last = op_index == cnt_q - 1'b1;
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      cnt_q         <= '0;
      pa            <= '0;
      pb            <= '0;
      pw            <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      ovf           <= 1'b0;
      op_index      <= '0;
      bus.m_araddr  <= '0;
      bus.m_arvalid <= 1'b0;
      bus.m_rready  <= 1'b0;
      bus.m_awaddr  <= '0;
      bus.m_awvalid <= 1'b0;
      bus.m_wdata   <= '0;
      bus.m_wvalid  <= 1'b0;
      bus.m_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_q   <= mode;
          cnt_q    <= count;
          pa       <= raddr1;
          pb       <= raddr2;
          pw       <= waddr;
          err      <= 1'b0;
          ovf      <= 1'b0;
          acc      <= '0;
          op_index <= '0;
          if (count == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            busy          <= 1'b1;
            bus.m_arvalid <= 1'b1;
            bus.m_araddr  <= raddr1;
            state         <= AR1;
          end
        end
        AR1: if (bus.s_arready) begin
          bus.m_arvalid <= 1'b0;
          bus.m_rready  <= 1'b1;
          state         <= R1;
        end
        R1: if (bus.s_rvalid) begin
          bus.m_rready <= 1'b0;
          if (bus.s_rresp != 2'd0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            a_q           <= bus.s_rdata;
            bus.m_arvalid <= 1'b1;
            bus.m_araddr  <= pb;
            state         <= AR2;
          end
        end
        AR2: if (bus.s_arready) begin
          bus.m_arvalid <= 1'b0;
          bus.m_rready  <= 1'b1;
          state         <= R2;
        end
        R2: if (bus.s_rvalid) begin
          bus.m_rready <= 1'b0;
          if (bus.s_rresp != 2'd0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            b_q   <= bus.s_rdata;
            state <= MUL;
          end
        end
        MUL: if (!mode_q) begin
          bus.m_awvalid <= 1'b1;
          bus.m_wvalid  <= 1'b1;
          bus.m_awaddr  <= pw;
          bus.m_wdata   <= prod;
          state         <= WR;
        end else begin
          acc <= sum[2*DW-1:0];
          ovf <= ovf | sum[2*DW];
          if (last) begin
            bus.m_awvalid <= 1'b1;
            bus.m_wvalid  <= 1'b1;
            bus.m_awaddr  <= pw;
            bus.m_wdata   <= sum[2*DW-1:0];
            state         <= WR;
          end else begin
            op_index      <= op_index + 1'b1;
            pa            <= pa + step;
            pb            <= pb + step;
            bus.m_arvalid <= 1'b1;
            bus.m_araddr  <= pa + step;
            state         <= AR1;
          end
        end
        WR: begin
          if (bus.s_awready) bus.m_awvalid <= 1'b0;
          if (bus.s_wready) bus.m_wvalid <= 1'b0;
          // each channel may have been accepted in an earlier cycle or in this one
          if ((!bus.m_awvalid || bus.s_awready) && (!bus.m_wvalid || bus.s_wready)) begin
            bus.m_bready <= 1'b1;
            state        <= B;
          end
        end
        B: if (bus.s_bvalid) begin
          bus.m_bready <= 1'b0;
          if (bus.s_bresp != 2'd0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (mode_q || last) begin
            op_index <= op_index + 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            op_index      <= op_index + 1'b1;
            pa            <= pa + step;
            pb            <= pb + step;
            pw            <= pw + step;
            bus.m_arvalid <= 1'b1;
            bus.m_araddr  <= pa + step;
            state         <= AR1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
